err_win_ctrl: RTL and testbench
===============================

Name: err_win_ctrl

Overview:
Measurement-window sequencer for the DC-error accumulator (err_dc_gen).
- Counts clk_en symbol strobes and drives the accumulator's hold input so that each window spans exactly 2^WIN_LOG2 accumulated symbols.
- Latches each full-precision window sum and presents it to a consumer (software/readout block) through a valid/ack handshake.
- Supports single-shot and continuous operation, and flags overruns.

Parameters:
WIN_LOG2, `LFSR_LEN, log2 of symbols accumulated per window (N = 2^WIN_LOG2)
ACC_W, 18+`LFSR_LEN, width of the full accumulator sum; must equal 18+WIN_LOG2
CNT_W, 16, width of the window sequence counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears all state and outputs
clk_en  in  1  symbol strobe, shared with the accumulator
start  in  1  one-cycle pulse: begin measurement
stop  in  1  one-cycle pulse: abort or end measurement
continuous  in  1  1 = back-to-back windows; 0 = single window; sampled when start is accepted
acc_full  in  ACC_W  signed accumulator sum (acc_out_full)
hold  out  1  to accumulator hold; registered
busy  out  1  high in any state other than IDLE
res_valid  out  1  result available
res_ack  in  1  consumer accepts result
res_sum  out  ACC_W  signed latched window sum
res_mean  out  18  res_sum[ACC_W-1:WIN_LOG2], the arithmetic-shift mean
res_seq  out  CNT_W  window index of the current result; wraps to 0 after all-ones
overrun  out  1  sticky; cleared only by reset or an accepted start

Behaviour:
Reset values: hold=0, busy=0, res_valid=0, res_sum=0, res_seq=0, overrun=0, sym_cnt=0, state=IDLE, mode=0, seq_next=0.

States:
- IDLE: hold=0.
  - start=1 → FLUSH; latch mode=continuous; clear overrun.
  - Clear seq_next to 0 on an accepted start.
- FLUSH: hold=1; clears stale accumulator contents.
  - On the first clk_en → ACCUM with sym_cnt=0.
  - The symbol on this strobe is discarded by the accumulator.
- ACCUM: hold=0.
  - Each clk_en increments sym_cnt.
  - When sym_cnt = N-1 and clk_en=1 → DUMP, sym_cnt=0.
  - Exactly N symbols are summed.
- DUMP: hold=1, asserted the cycle after the Nth strobe, i.e. before the next clk_en.
  - On the next clk_en:
    - res_sum ← acc_full (value stable during DUMP).
    - res_seq ← seq_next; seq_next increments.
    - res_valid ← 1.
  - Next state: ACCUM if mode=1, otherwise IDLE.
  - The DUMP strobe's symbol is discarded, so the continuous window period is N+1 strobes.

hold rule: hold is a pure function of the registered state (FLUSH or DUMP). It never depends combinationally on clk_en.

Handshake:
- res_valid stays high until a cycle with res_ack=1, which clears it the following cycle.
- If a new result is latched while res_valid=1 and res_ack=0: the result is overwritten, res_valid stays 1, overrun ← 1.
- If res_ack=1 and a new latch occur in the same cycle: the new result wins, res_valid stays 1, overrun is unchanged.
- res_ack while res_valid=0 is ignored.

Boundaries:
- stop in FLUSH or ACCUM → IDLE next cycle; no result; sym_cnt cleared.
- stop in DUMP → finish the dump (result produced), then IDLE regardless of mode.
- stop and start in the same cycle in IDLE: start wins.
- start while busy: ignored.
- clk_en held high every cycle: FLUSH and DUMP each last exactly one cycle.
- clk_en low indefinitely: the FSM waits and hold stays at its state value.
- Synchronous reset mid-window → IDLE next edge, hold=0, result discarded.
- The accumulator's own asynchronous reset must be tied to the same reset net. A subsequent start always passes through FLUSH, so stale sums never reach res_sum.

Latency: res_valid rises 1 clk after the DUMP clk_en edge, i.e. it is registered at that edge.

Decomposition:
- Shared package/defines (defines.vh): state encodings ST_IDLE=0, ST_FLUSH=1, ST_ACCUM=2, ST_DUMP=3; default WIN_LOG2 tied to `LFSR_LEN.
- One natural sub-module: err_win_cnt, the WIN_LOG2-bit symbol counter with clk_en and clear inputs and a terminal-count output (cnt==N-1 && clk_en).
- The result register and handshake stay in the top module.

Test Plan:
All scenarios use WIN_LOG2=2 (N=4), with clk_en on every 2nd cycle unless stated.
1. Single shot: start with continuous=0, err=5 constant into err_dc_gen → hold high for 1 strobe, then 4 accumulated strobes, then hold → res_sum=20, res_mean=5, res_seq=0, res_valid=1, busy=0, overrun=0.
2. Continuous, err=-3, res_ack pulsed after each result → res_sum=-12, res_mean=-3; res_seq=0,1,2; results spaced 5 strobes (10 clks) apart; overrun=0.
3. Continuous with res_ack never asserted → second result overwrites, res_seq=1, overrun=1. A later start clears overrun; reset also clears it.
4. stop issued after 2 ACCUM strobes → IDLE next cycle, no res_valid, hold=0. A re-start performs FLUSH, and the next result = 4×err exactly.
5. clk_en tied high, err ramp 1,2,3,4 after FLUSH → res_sum=10. Synchronous reset asserted mid-ACCUM in a second run → all outputs 0 next cycle.
6. res_ack coincident with a new DUMP latch → res_valid remains 1, new res_seq shown, overrun unchanged.

Source files
------------

// File: rtl/err_win_ctrl_pkg.sv
// Shared definitions for the DC-error measurement-window sequencer.
// Holds the FSM state encoding and the default window size.
package err_win_ctrl_pkg;

  localparam int LFSR_LEN     = 2;
  localparam int DEF_WIN_LOG2 = LFSR_LEN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DUMP  = 2'd3
  } state_e;

endpackage

// File: rtl/err_win_cnt.sv
// Symbol counter for one measurement window.
// tc pulses on the strobe that completes the 2^W-th symbol.
module err_win_cnt #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic clear,
  output logic tc
);

  logic [W-1:0] cnt;

  // Wrapping from all-ones back to 0 leaves the counter ready for the next window.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (clk_en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == {W{1'b1}}) && clk_en;

endmodule

// File: rtl/err_win_ctrl.sv
// Measurement-window sequencer for the DC-error accumulator: drives hold,
// latches each window sum and hands it to a consumer through valid/ack.
module err_win_ctrl
  import err_win_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int ACC_W    = 18 + WIN_LOG2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [ACC_W-1:0]   acc_full,
  output logic               hold,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ack,
  output logic [ACC_W-1:0]   res_sum,
  output logic [17:0]        res_mean,
  output logic [CNT_W-1:0]   res_seq,
  output logic               overrun,
  output state_e             state_dbg
);

  // Handshake: res_valid rises on the edge that latches a result and stays
  // high until a cycle with res_ack=1; a latch in that same cycle wins.

  state_e             state_q, state_d;
  logic               mode_q, stop_q, hold_q;
  logic               res_valid_q, overrun_q;
  logic [ACC_W-1:0]   res_sum_q;
  logic [CNT_W-1:0]   res_seq_q, seq_next_q;
  logic               tc, do_start, latch, cnt_en, cnt_clr, dump_stop;

  assign do_start  = (state_q == ST_IDLE) && start;
  assign latch     = (state_q == ST_DUMP) && clk_en;
  assign cnt_en    = (state_q == ST_ACCUM) && clk_en;
  assign cnt_clr   = (state_q != ST_ACCUM) || stop;
  assign dump_stop = stop || stop_q;

  err_win_cnt #(.W(WIN_LOG2)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clk_en (cnt_en),
    .clear  (cnt_clr),
    .tc     (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (stop)        state_d = ST_IDLE;
        else if (clk_en) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (stop)    state_d = ST_IDLE;
        else if (tc) state_d = ST_DUMP;
      end
      ST_DUMP:  if (clk_en) state_d = (mode_q && !dump_stop) ? ST_ACCUM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= 1'b0;
      mode_q      <= 1'b0;
      stop_q      <= 1'b0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      res_sum_q   <= '0;
      res_seq_q   <= '0;
      seq_next_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_d == ST_FLUSH) || (state_d == ST_DUMP);
      // A stop seen while waiting in DUMP must survive until the dump strobe.
      stop_q  <= (state_d == ST_DUMP) && dump_stop;
      if (do_start) begin
        mode_q     <= continuous;
        seq_next_q <= '0;
        overrun_q  <= 1'b0;
      end
      if (latch) begin
        res_sum_q   <= acc_full;
        res_seq_q   <= seq_next_q;
        seq_next_q  <= seq_next_q + CNT_W'(1);
        res_valid_q <= 1'b1;
        if (res_valid_q && !res_ack) overrun_q <= 1'b1;
      end else if (res_ack) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign hold      = hold_q;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_mean  = res_sum_q[ACC_W-1:WIN_LOG2];
  assign res_seq   = res_seq_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_err_win_ctrl.sv
// Directed bench for err_win_ctrl with N=4, driving acc_full from a small
// accumulator that clears on hold strobes and sums err otherwise.
module tb_err_win_ctrl;
  import err_win_ctrl_pkg::*;

  localparam int WL = 2;
  localparam int AW = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, clk_en, start, stop, continuous, res_ack;
  logic [AW-1:0] acc_full;
  logic          hold, busy, res_valid, overrun;
  logic [AW-1:0] res_sum;
  logic [17:0]   res_mean;
  logic [CW-1:0] res_seq;
  state_e        state_dbg;

  logic [AW-1:0] acc;
  int            err, en_mode, phase, cyc, n_cmp, n_bad;

  err_win_ctrl #(.WIN_LOG2(WL), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .stop(stop),
    .continuous(continuous), .acc_full(acc_full), .hold(hold), .busy(busy),
    .res_valid(res_valid), .res_ack(res_ack), .res_sum(res_sum),
    .res_mean(res_mean), .res_seq(res_seq), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)       acc <= '0;
    else if (clk_en) acc <= hold ? '0 : acc + AW'(err);
  end
  assign acc_full = acc;

  task automatic cycle();
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; res_ack = 1'b0;
    cyc++; phase++;
    clk_en = (en_mode != 0) ? 1'b1 : phase[0];
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!res_valid && n < 60) begin cycle(); n++; end
    n_cmp++;
    if (!res_valid) begin n_bad++; $display("FAIL %s_timeout res_valid got 0 want 1", name); end
  endtask

  task automatic stop_and_idle();
    int n = 0;
    stop = 1'b1;
    cycle();
    while (busy && n < 10) begin cycle(); n++; end
    res_ack = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; continuous = 0; res_ack = 0; clk_en = 0; err = 0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    n_cmp++; if (hold !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_ctl hold=%b busy=%b want 0 0", hold, busy); end
    n_cmp++; if (res_valid !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL rst_flags valid=%b ovr=%b want 0 0", res_valid, overrun); end
    n_cmp++; if (res_sum !== '0 || res_seq !== '0) begin n_bad++; $display("FAIL rst_res sum=%0d seq=%0d want 0 0", res_sum, res_seq); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_single_shot();
    err = 5; continuous = 0;
    repeat (3) cycle();
    start = 1'b1;
    cycle();
    n_cmp++; if (state_dbg !== ST_FLUSH || hold !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL t1_flush state=%0d hold=%b busy=%b want 1 1 1", state_dbg, hold, busy); end
    wait_valid("t1");
    n_cmp++; if (res_sum !== 20'd20) begin n_bad++; $display("FAIL t1_sum got %0d want 20", $signed(res_sum)); end
    n_cmp++; if (res_mean !== 18'd5) begin n_bad++; $display("FAIL t1_mean got %0d want 5", $signed(res_mean)); end
    n_cmp++; if (res_seq !== 16'd0) begin n_bad++; $display("FAIL t1_seq got %0d want 0", res_seq); end
    n_cmp++; if (busy !== 1'b0 || overrun !== 1'b0 || hold !== 1'b0) begin n_bad++; $display("FAIL t1_end busy=%b ovr=%b hold=%b want 0 0 0", busy, overrun, hold); end
    res_ack = 1'b1;
    cycle();
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL t1_ack valid got %b want 0", res_valid); end
  endtask

  task automatic test_continuous();
    logic [AW-1:0] exp_sum;
    logic [17:0]   exp_mean;
    int            t_prev;
    exp_sum = AW'(-12); exp_mean = 18'(-3); t_prev = 0;
    err = -3; continuous = 1;
    start = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      wait_valid("t2");
      n_cmp++; if (res_sum !== exp_sum || res_mean !== exp_mean) begin n_bad++; $display("FAIL t2_sum[%0d] sum=%0d mean=%0d want -12 -3", i, $signed(res_sum), $signed(res_mean)); end
      n_cmp++; if (res_seq !== CW'(i)) begin n_bad++; $display("FAIL t2_seq[%0d] got %0d want %0d", i, res_seq, i); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL t2_ovr[%0d] got %b want 0", i, overrun); end
      if (i > 0) begin
        n_cmp++; if (cyc - t_prev != 10) begin n_bad++; $display("FAIL t2_period[%0d] got %0d want 10", i, cyc - t_prev); end
      end
      t_prev = cyc;
      res_ack = 1'b1;
      cycle();
    end
    stop_and_idle();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_stop busy got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    int n;
    err = 1; continuous = 1;
    start = 1'b1;
    cycle();
    n = 0;
    while (!(res_valid && res_seq == 16'd1) && n < 60) begin cycle(); n++; end
    n_cmp++; if (res_seq !== 16'd1 || res_valid !== 1'b1) begin n_bad++; $display("FAIL t3_seq got %0d valid=%b want 1 1", res_seq, res_valid); end
    n_cmp++; if (overrun !== 1'b1 || res_sum !== 20'd4) begin n_bad++; $display("FAIL t3_ovr ovr=%b sum=%0d want 1 4", overrun, res_sum); end
    stop_and_idle();
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL t3_sticky got %b want 1", overrun); end
    continuous = 0;
    start = 1'b1;
    cycle();
    n_cmp++; if (overrun !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL t3_startclr ovr=%b busy=%b want 0 1", overrun, busy); end
    stop_and_idle();
    continuous = 1;
    start = 1'b1;
    cycle();
    n = 0;
    while (!overrun && n < 60) begin cycle(); n++; end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL t3_reovr got %b want 1", overrun); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++; if (overrun !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL t3_rstclr ovr=%b valid=%b busy=%b want 0 0 0", overrun, res_valid, busy); end
    cycle();
  endtask

  task automatic test_stop_accum();
    int n, strobes;
    err = 7; continuous = 0;
    start = 1'b1;
    cycle();
    n = 0;
    while (state_dbg != ST_ACCUM && n < 10) begin cycle(); n++; end
    strobes = 0;
    while (strobes < 2) begin
      if (clk_en) strobes++;
      cycle();
    end
    stop = 1'b1;
    cycle();
    n_cmp++; if (state_dbg !== ST_IDLE || busy !== 1'b0 || hold !== 1'b0) begin n_bad++; $display("FAIL t4_stop state=%0d busy=%b hold=%b want 0 0 0", state_dbg, busy, hold); end
    repeat (12) cycle();
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL t4_noresult valid got %b want 0", res_valid); end
    start = 1'b1;
    cycle();
    wait_valid("t4");
    n_cmp++; if (res_sum !== 20'd28 || res_seq !== 16'd0) begin n_bad++; $display("FAIL t4_restart sum=%0d seq=%0d want 28 0", $signed(res_sum), res_seq); end
    res_ack = 1'b1;
    cycle();
  endtask

  task automatic test_back_to_back();
    en_mode = 1;
    cycle();
    continuous = 0;
    start = 1'b1;
    cycle();
    n_cmp++; if (state_dbg !== ST_FLUSH || hold !== 1'b1) begin n_bad++; $display("FAIL t5_flush state=%0d hold=%b want 1 1", state_dbg, hold); end
    cycle();
    n_cmp++; if (state_dbg !== ST_ACCUM || hold !== 1'b0) begin n_bad++; $display("FAIL t5_accum state=%0d hold=%b want 2 0", state_dbg, hold); end
    for (int k = 1; k <= 4; k++) begin
      err = k;
      cycle();
    end
    n_cmp++; if (state_dbg !== ST_DUMP || hold !== 1'b1) begin n_bad++; $display("FAIL t5_dump state=%0d hold=%b want 3 1", state_dbg, hold); end
    cycle();
    n_cmp++; if (res_valid !== 1'b1 || res_sum !== 20'd10) begin n_bad++; $display("FAIL t5_sum valid=%b sum=%0d want 1 10", res_valid, $signed(res_sum)); end
    n_cmp++; if (state_dbg !== ST_IDLE || hold !== 1'b0) begin n_bad++; $display("FAIL t5_idle state=%0d hold=%b want 0 0", state_dbg, hold); end
    res_ack = 1'b1;
    cycle();
    continuous = 1;
    start = 1'b1;
    cycle(); cycle(); cycle();
    n_cmp++; if (state_dbg !== ST_ACCUM) begin n_bad++; $display("FAIL t5_midwin state=%0d want 2", state_dbg); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++; if (hold !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL t5_rst_ctl hold=%b busy=%b valid=%b ovr=%b want 0 0 0 0", hold, busy, res_valid, overrun); end
    n_cmp++; if (res_sum !== '0 || res_seq !== '0 || res_mean !== '0) begin n_bad++; $display("FAIL t5_rst_res sum=%0d seq=%0d mean=%0d want 0 0 0", res_sum, res_seq, res_mean); end
    en_mode = 0;
    cycle();
  endtask

  task automatic test_ack_with_latch();
    int n;
    err = 2; continuous = 1;
    start = 1'b1;
    cycle();
    wait_valid("t6");
    n_cmp++; if (res_seq !== 16'd0) begin n_bad++; $display("FAIL t6_first seq got %0d want 0", res_seq); end
    n = 0;
    while (!(state_dbg == ST_DUMP && clk_en) && n < 40) begin cycle(); n++; end
    res_ack = 1'b1;
    cycle();
    n_cmp++; if (res_valid !== 1'b1 || res_seq !== 16'd1) begin n_bad++; $display("FAIL t6_coinc valid=%b seq=%0d want 1 1", res_valid, res_seq); end
    n_cmp++; if (overrun !== 1'b0 || res_sum !== 20'd8) begin n_bad++; $display("FAIL t6_ovr ovr=%b sum=%0d want 0 8", overrun, $signed(res_sum)); end
    stop_and_idle();
  endtask

  task automatic test_stop_in_dump();
    int n;
    err = 3; continuous = 1;
    start = 1'b1;
    cycle();
    n = 0;
    while (!(state_dbg == ST_DUMP && !clk_en) && n < 40) begin cycle(); n++; end
    stop = 1'b1;
    cycle();
    n_cmp++; if (state_dbg !== ST_DUMP || busy !== 1'b1) begin n_bad++; $display("FAIL t7_hold state=%0d busy=%b want 3 1", state_dbg, busy); end
    cycle();
    n_cmp++; if (state_dbg !== ST_IDLE || res_valid !== 1'b1 || res_sum !== 20'd12) begin n_bad++; $display("FAIL t7_finish state=%0d valid=%b sum=%0d want 0 1 12", state_dbg, res_valid, $signed(res_sum)); end
    res_ack = 1'b1;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; phase = 0; en_mode = 0;
    test_reset();
    test_single_shot();
    test_continuous();
    test_overrun();
    test_stop_accum();
    test_back_to_back();
    test_ack_with_latch();
    test_stop_in_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
